ad9826_line_packer: RTL and testbench

Sits between the AD9826 byte interface (`adc9826` capture path) and the pldata RAM port of `zynq_sys_wrapper`. Assembles the AD9826's multiplexed 8-bit output (high byte then low byte per pixel) into 16-bit pixels. Packs two pixels per 32-bit RAM word and generates byte-addressed RAM writes for one G11620 line per start. Signals line completion to the PS as a one-cycle done pulse and a level interrupt held until acknowledged.

---
 rtl/ad9826_pkg.sv | 20 ++
 rtl/ad9826_byte_pair.sv | 37 +++
 rtl/ad9826_line_packer.sv | 151 +++++++++++++++
 tb/tb_ad9826_line_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9826_pkg.sv
// ad9826_pkg: shared types and constants for the AD9826 line packer.
//   state_t   - line packer FSM states
//   PIX_W     - assembled pixel width
//   WORD_W    - RAM word width (two pixels)
//   ADDR_STEP - byte-address increment per RAM word
package ad9826_pkg;

    localparam int PIX_W     = 16;
    localparam int WORD_W    = 32;
    localparam int ADDR_STEP = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ad9826_byte_pair.sv
// ad9826_byte_pair: joins the AD9826 multiplexed byte stream into pixels.
// Ports:
//   clk, rst_n   - pixel clock, asynchronous active-low reset
//   hi_en        - FSM is waiting for a high byte
//   lo_en        - FSM is waiting for a low byte
//   data, valid  - AD9826 byte and its qualifier
//   pixel        - {latched high byte, current byte}
//   pixel_valid  - pixel is complete this cycle
module ad9826_byte_pair
    import ad9826_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hi_en,
    input  logic             lo_en,
    input  logic [7:0]       data,
    input  logic             valid,
    output logic [PIX_W-1:0] pixel,
    output logic             pixel_valid
);

    logic [7:0] hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (hi_en && valid) begin
            hi_q <= data;
        end
    end

    // Pixel is formed combinationally in the LO cycle so the packer can
    // register it (and any resulting write) on the very next edge.
    assign pixel       = {hi_q, data};
    assign pixel_valid = lo_en & valid;

endmodule

// File: rtl/ad9826_line_packer.sv
// ad9826_line_packer: packs AD9826 byte pairs into 32-bit RAM words for one
// line per start, then raises a done pulse and a level interrupt.
// Parameters: PIXELS (pixels per line), ADDR_W (RAM byte-address width).
// Ports:
//   clk, rst_n        - pixel clock, asynchronous active-low reset
//   start_in          - arms capture of one line
//   byte_in/_valid_in - AD9826 byte stream (high byte, then low byte)
//   irq_ack_in        - clears irq_o
//   test_mode_in      - replace pixels with their index (TEST_PATTERN_EN only)
//   ram_wr_o/addr_o/data_o - RAM write port, byte addressed, word aligned
//   busy_o, done_o, irq_o, err_o, line_cnt_o - status
// Build option: define TEST_PATTERN_EN to enable the index test pattern.
module ad9826_line_packer
    import ad9826_pkg::*;
#(
    parameter int PIXELS = 256,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid_in,
    input  logic              irq_ack_in,
    input  logic              test_mode_in,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [WORD_W-1:0] ram_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              irq_o,
    output logic              err_o,
    output logic [15:0]       line_cnt_o
);

    localparam int              CNT_W    = $clog2(PIXELS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);
    localparam bit              ODD_LINE = (PIXELS % 2) == 1;

    state_t            state;
    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  word_lo;
    logic [PIX_W-1:0]  pair_pixel;
    logic [PIX_W-1:0]  pixel;
    logic              pair_valid;

    ad9826_byte_pair u_byte_pair (
        .clk         (clk),
        .rst_n       (rst_n),
        .hi_en       (state == ST_HI),
        .lo_en       (state == ST_LO),
        .data        (byte_in),
        .valid       (byte_valid_in),
        .pixel       (pair_pixel),
        .pixel_valid (pair_valid)
    );

`ifdef TEST_PATTERN_EN
    always_comb begin
        pixel = test_mode_in ? PIX_W'(pix_cnt) : pair_pixel;
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode_in;
    assign pixel            = pair_pixel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pix_cnt    <= '0;
            addr       <= '0;
            word_lo    <= '0;
            ram_wr_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            irq_o      <= 1'b0;
            err_o      <= 1'b0;
            line_cnt_o <= '0;
        end else begin
            ram_wr_o <= 1'b0;
            done_o   <= 1'b0;

            // busy_o trails the FSM by one cycle at the end so it stays up
            // through the done pulse; start is only accepted once it drops.
            if (done_o) begin
                busy_o <= 1'b0;
            end
            if (start_in && busy_o) begin
                err_o <= 1'b1;
            end
            // Ack clears first; a DONE set below in the same cycle wins.
            if (irq_ack_in) begin
                irq_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_in && !busy_o) begin
                        pix_cnt <= '0;
                        addr    <= '0;
                        err_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (byte_valid_in) begin
                        state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (pair_valid) begin
                        if (!pix_cnt[0]) begin
                            word_lo <= pixel;
                        end else begin
                            ram_wr_o   <= 1'b1;
                            ram_addr_o <= addr;
                            ram_data_o <= {pixel, word_lo};
                            addr       <= addr + ADDR_W'(ADDR_STEP);
                        end
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST_IDX) begin
                            state <= ODD_LINE ? ST_FLUSH : ST_DONE;
                        end else begin
                            state <= ST_HI;
                        end
                    end
                end
                ST_FLUSH: begin
                    ram_wr_o   <= 1'b1;
                    ram_addr_o <= addr;
                    ram_data_o <= {PIX_W'(0), word_lo};
                    addr       <= addr + ADDR_W'(ADDR_STEP);
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    done_o     <= 1'b1;
                    irq_o      <= 1'b1;
                    line_cnt_o <= line_cnt_o + 16'd1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9826_line_packer.sv
// Testbench for ad9826_line_packer: an even-length (PIXELS=4) and an
// odd-length (PIXELS=3) instance share one stimulus stream.
module tb_ad9826_line_packer;

    logic        clk;
    logic        rst_n;
    logic        start_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        irq_ack_in;
    logic        test_mode_in;

    logic        e_wr, o_wr;
    logic [9:0]  e_addr, o_addr;
    logic [31:0] e_data, o_data;
    logic        e_busy, o_busy, e_done, o_done, e_irq, o_irq, e_err, o_err;
    logic [15:0] e_cnt, o_cnt;

    int checks   = 0;
    int failures = 0;

    ad9826_line_packer #(.PIXELS(4), .ADDR_W(10)) u_even (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .byte_in(byte_in),
        .byte_valid_in(byte_valid_in), .irq_ack_in(irq_ack_in),
        .test_mode_in(test_mode_in), .ram_wr_o(e_wr), .ram_addr_o(e_addr),
        .ram_data_o(e_data), .busy_o(e_busy), .done_o(e_done), .irq_o(e_irq),
        .err_o(e_err), .line_cnt_o(e_cnt)
    );

    ad9826_line_packer #(.PIXELS(3), .ADDR_W(10)) u_odd (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .byte_in(byte_in),
        .byte_valid_in(byte_valid_in), .irq_ack_in(irq_ack_in),
        .test_mode_in(test_mode_in), .ram_wr_o(o_wr), .ram_addr_o(o_addr),
        .ram_data_o(o_data), .busy_o(o_busy), .done_o(o_done), .irq_o(o_irq),
        .err_o(o_err), .line_cnt_o(o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write / done logs, sampled on the falling edge.
    int          cyc = 0;
    logic [9:0]  e_wa [64];
    logic [31:0] e_wd [64];
    int          e_wc [64];
    int          e_n = 0;
    logic [9:0]  o_wa [64];
    logic [31:0] o_wd [64];
    int          o_n = 0;
    int          e_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (e_wr && e_n < 64) begin
            e_wa[e_n] = e_addr; e_wd[e_n] = e_data; e_wc[e_n] = cyc; e_n = e_n + 1;
        end
        if (o_wr && o_n < 64) begin
            o_wa[o_n] = o_addr; o_wd[o_n] = o_data; o_n = o_n + 1;
        end
        if (e_done) e_done_cyc = cyc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] b, input logic v, input logic a);
        start_in = s; byte_in = b; byte_valid_in = v; irq_ack_in = a;
    endtask

    task automatic send_line(input bit gap, input bit mid_start);
        logic [7:0] bs [8];
        bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 8; i++) begin
            drive(mid_start && i == 3, bs[i], 1'b1, 1'b0);
            tick();
            if (gap) begin
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                tick();
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && (e_busy || o_busy); k++) tick();
        chk("idle_timeout", {30'd0, e_busy, o_busy}, 32'd0);
    endtask

    task automatic pulse_start();
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pulse_ack();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        done;
        logic        irq;
        logic        busy;
    } exp_t;

    typedef struct {
        logic       start;
        logic [7:0] b;
        logic       v;
        logic       ack;
        exp_t       e;
        exp_t       o;
    } vec_t;

    function automatic exp_t ex(input logic wr, input logic [9:0] a, input logic [31:0] d,
                                input logic dn, input logic irq, input logic busy);
        ex.wr = wr; ex.addr = a; ex.data = d; ex.done = dn; ex.irq = irq; ex.busy = busy;
    endfunction

    function automatic vec_t mk(input logic s, input logic [7:0] b, input logic v,
                                input logic a, input exp_t e, input exp_t o);
        mk.start = s; mk.b = b; mk.v = v; mk.ack = a; mk.e = e; mk.o = o;
    endfunction

    task automatic chk_exp(input string who, input int row, input exp_t x,
                           input logic wr, input logic [9:0] addr, input logic [31:0] data,
                           input logic dn, input logic irq, input logic busy);
        chk($sformatf("%s_wr[%0d]", who, row), {31'd0, wr}, {31'd0, x.wr});
        if (x.wr) begin
            chk($sformatf("%s_addr[%0d]", who, row), {22'd0, addr}, {22'd0, x.addr});
            chk($sformatf("%s_data[%0d]", who, row), data, x.data);
        end
        chk($sformatf("%s_done[%0d]", who, row), {31'd0, dn}, {31'd0, x.done});
        chk($sformatf("%s_irq[%0d]", who, row), {31'd0, irq}, {31'd0, x.irq});
        chk($sformatf("%s_busy[%0d]", who, row), {31'd0, busy}, {31'd0, x.busy});
    endtask

    vec_t vecs [12];
    int   base;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Back-to-back even line; odd instance flushes on the 3rd pixel.
        vecs[0]  = mk(1, 8'h00, 0, 0, ex(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1));
        vecs[1]  = mk(0, 8'h12, 1, 0, ex(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1));
        vecs[2]  = mk(0, 8'h34, 1, 0, ex(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1));
        vecs[3]  = mk(0, 8'h56, 1, 0, ex(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1));
        vecs[4]  = mk(0, 8'h78, 1, 0, ex(1, 0, 32'h56781234, 0, 0, 1),
                                      ex(1, 0, 32'h56781234, 0, 0, 1));
        vecs[5]  = mk(0, 8'h9A, 1, 0, ex(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1));
        vecs[6]  = mk(0, 8'hBC, 1, 0, ex(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1));
        vecs[7]  = mk(0, 8'hDE, 1, 0, ex(0, 0, 0, 0, 0, 1),
                                      ex(1, 4, 32'h00009ABC, 0, 0, 1));
        vecs[8]  = mk(0, 8'hF0, 1, 0, ex(1, 4, 32'hDEF09ABC, 0, 0, 1),
                                      ex(0, 0, 0, 1, 1, 1));
        // Ack lands in the even DONE cycle (set wins) and clears the odd irq.
        vecs[9]  = mk(0, 8'h00, 0, 1, ex(0, 0, 0, 1, 1, 1), ex(0, 0, 0, 0, 0, 0));
        vecs[10] = mk(0, 8'h00, 0, 0, ex(0, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0));
        vecs[11] = mk(0, 8'h00, 0, 1, ex(0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0));

        rst_n = 1'b0; test_mode_in = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        chk("reset_outputs_even", {e_wr, e_busy, e_done, e_irq, e_err, e_cnt, e_addr, 1'b0},
            32'd0);
        chk("reset_data_even", e_data, 32'd0);
        chk("reset_outputs_odd", {o_wr, o_busy, o_done, o_irq, o_err, o_cnt, o_addr, 1'b0},
            32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].start, vecs[i].b, vecs[i].v, vecs[i].ack);
            tick();
            chk_exp("even", i, vecs[i].e, e_wr, e_addr, e_data, e_done, e_irq, e_busy);
            chk_exp("odd", i, vecs[i].o, o_wr, o_addr, o_data, o_done, o_irq, o_busy);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("table_line_cnt_even", {16'd0, e_cnt}, 32'd1);
        chk("table_line_cnt_odd", {16'd0, o_cnt}, 32'd1);
        chk("table_err_even", {31'd0, e_err}, 32'd0);

        // Gapped input: same words, done one cycle after the last write.
        base = e_n;
        pulse_start();
        send_line(1'b1, 1'b0);
        wait_idle();
        chk("gap_wr_count_even", e_n - base, 2);
        chk("gap_addr0_even", {22'd0, e_wa[base]}, 32'd0);
        chk("gap_data0_even", e_wd[base], 32'h56781234);
        chk("gap_addr1_even", {22'd0, e_wa[base+1]}, 32'd4);
        chk("gap_data1_even", e_wd[base+1], 32'hDEF09ABC);
        chk("gap_done_latency", e_done_cyc - e_wc[base+1], 1);
        chk("gap_wr_count_odd", o_n - (base - 0), 2);
        chk("gap_data1_odd", o_wd[base+1], 32'h00009ABC);
        chk("gap_addr1_odd", {22'd0, o_wa[base+1]}, 32'd4);
        chk("gap_line_cnt_even", {16'd0, e_cnt}, 32'd2);
        pulse_ack();
        chk("late_ack_irq", {30'd0, e_irq, o_irq}, 32'd0);

        // Start while busy: err set, line unchanged.
        base = e_n;
        pulse_start();
        send_line(1'b0, 1'b1);
        chk("busy_start_err", {30'd0, e_err, o_err}, 32'd3);
        wait_idle();
        chk("busy_wr_count", e_n - base, 2);
        chk("busy_data0", e_wd[base], 32'h56781234);
        chk("busy_data1", e_wd[base+1], 32'hDEF09ABC);
        chk("busy_line_cnt", {16'd0, e_cnt}, 32'd3);
        pulse_ack();

        // Next accepted start clears err; reset mid-line after 3 bytes.
        base = e_n;
        pulse_start();
        chk("start_clears_err", {30'd0, e_err, o_err}, 32'd0);
        drive(1'b0, 8'h12, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h34, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h56, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_no_write", e_n - base, 0);
        chk("midreset_outputs_even", {e_wr, e_busy, e_done, e_irq, e_err, e_cnt, e_addr, 1'b0},
            32'd0);
        chk("midreset_data_even", e_data, 32'd0);
        chk("midreset_outputs_odd", {o_wr, o_busy, o_done, o_irq, o_err, o_cnt, o_addr, 1'b0},
            32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        base = e_n;
        pulse_start();
        send_line(1'b0, 1'b0);
        wait_idle();
        chk("post_reset_addr0", {22'd0, e_wa[base]}, 32'd0);
        chk("post_reset_data0", e_wd[base], 32'h56781234);
        chk("post_reset_line_cnt", {e_cnt, o_cnt}, 32'h00010001);
        pulse_ack();

`ifdef TEST_PATTERN_EN
        test_mode_in = 1'b1;
        base = e_n;
        pulse_start();
        send_line(1'b0, 1'b0);
        wait_idle();
        chk("pattern_w0_even", e_wd[base], 32'h00010000);
        chk("pattern_w1_even", e_wd[base+1], 32'h00030002);
        chk("pattern_w0_odd", o_wd[base], 32'h00010000);
        chk("pattern_w1_odd", o_wd[base+1], 32'h00000002);
        test_mode_in = 1'b0;
        pulse_ack();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
